// File: rtl/missile_scheduler.sv
// Player fire-edge launcher plus a shared-slot enemy missile scheduler (IDLE/COOLDOWN/SELECT/FIRE).
// Define MISSILE_SCHED_FIRE_BUFFER_EN to hold a fire press made while the player missile is still in flight.
module missile_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int NUM_COLS       = 8,
    parameter int ENEMY_COOLDOWN = 60,
    localparam int CW            = $clog2(NUM_COLS)
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 game_active,
    input  logic                 player_fire,
    input  logic                 player_busy,
    input  logic [NUM_SLOTS-1:0] enemy_busy,
    input  logic [NUM_COLS-1:0]  col_alive,
    output logic                 player_shoot,
    output logic [NUM_SLOTS-1:0] enemy_shoot,
    output logic [CW-1:0]        enemy_col,
    output logic [1:0]           sched_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_SELECT   = 2'd2,
        ST_FIRE     = 2'd3
    } sched_state_t;

    localparam logic [7:0] CD_RELOAD = 8'(ENEMY_COOLDOWN - 1);

    sched_state_t         state_r;
    logic [7:0]           cd_cnt_r;
    logic [CW-1:0]        col_ptr_r;
    logic                 fire_prev_r;
    logic                 fire_edge_s;
    logic                 can_launch_s;
    logic [NUM_SLOTS-1:0] slot_oh_s;
    logic [CW-1:0]        sel_col_s;
    logic [CW-1:0]        next_ptr_s;
`ifdef MISSILE_SCHED_FIRE_BUFFER_EN
    logic                 pending_r;
    logic                 blocked_s;
`endif

    // One-hot of the lowest-index free slot; all-zero when every slot is busy.
    function automatic logic [NUM_SLOTS-1:0] lowest_free(input logic [NUM_SLOTS-1:0] busy);
        logic [NUM_SLOTS-1:0] oh;
        logic                 found;
        oh    = '0;
        found = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (!found && !busy[s]) begin
                oh[s] = 1'b1;
                found = 1'b1;
            end
        end
        return oh;
    endfunction

    // First alive column at or after ptr, searching cyclically.
    function automatic logic [CW-1:0] next_alive_col(input logic [NUM_COLS-1:0] alive,
                                                     input logic [CW-1:0]       ptr);
        logic [CW-1:0] sel;
        logic [CW-1:0] cand;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) begin
            idx  = int'(ptr) + i;
            idx  = (idx >= NUM_COLS) ? idx - NUM_COLS : idx;
            cand = CW'(idx);
            if (!found && alive[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Launch qualification and target selection.
    always_comb begin
        fire_edge_s  = player_fire & ~fire_prev_r;
        slot_oh_s    = lowest_free(enemy_busy);
        sel_col_s    = next_alive_col(col_alive, col_ptr_r);
        can_launch_s = (~&enemy_busy) & (|col_alive);
        if (enemy_col == CW'(NUM_COLS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = enemy_col + CW'(1);
        end
`ifdef MISSILE_SCHED_FIRE_BUFFER_EN
        // The cycle of a launch counts as busy so pulses never sit back to back.
        blocked_s = player_busy | player_shoot;
`endif
    end

    // Player launch path, independent of the enemy scheduler.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            fire_prev_r  <= 1'b0;
            player_shoot <= 1'b0;
`ifdef MISSILE_SCHED_FIRE_BUFFER_EN
            pending_r    <= 1'b0;
`endif
        end else begin
            fire_prev_r <= player_fire;
`ifdef MISSILE_SCHED_FIRE_BUFFER_EN
            if ((fire_edge_s || pending_r) && !blocked_s) begin
                player_shoot <= 1'b1;
                pending_r    <= 1'b0;
            end else if (fire_edge_s) begin
                player_shoot <= 1'b0;
                pending_r    <= 1'b1;
            end else begin
                player_shoot <= 1'b0;
                pending_r    <= pending_r;
            end
`else
            player_shoot <= fire_edge_s & ~player_busy;
`endif
        end
    end

    // Enemy scheduler FSM; launch outputs are loaded on entry to FIRE so they align with it.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            cd_cnt_r    <= 8'd0;
            col_ptr_r   <= '0;
            enemy_shoot <= '0;
            enemy_col   <= '0;
        end else begin
            if (state_r == ST_FIRE) begin
                col_ptr_r <= next_ptr_s;
            end else begin
                col_ptr_r <= col_ptr_r;
            end
            if (!game_active) begin
                state_r     <= ST_IDLE;
                cd_cnt_r    <= cd_cnt_r;
                enemy_shoot <= '0;
                enemy_col   <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r     <= ST_COOLDOWN;
                        cd_cnt_r    <= CD_RELOAD;
                        enemy_shoot <= '0;
                        enemy_col   <= '0;
                    end
                    ST_COOLDOWN: begin
                        if (cd_cnt_r == 8'd0) begin
                            state_r  <= ST_SELECT;
                            cd_cnt_r <= cd_cnt_r;
                        end else begin
                            state_r  <= ST_COOLDOWN;
                            cd_cnt_r <= cd_cnt_r - 8'd1;
                        end
                        enemy_shoot <= '0;
                        enemy_col   <= '0;
                    end
                    ST_SELECT: begin
                        cd_cnt_r <= cd_cnt_r;
                        if (can_launch_s) begin
                            state_r     <= ST_FIRE;
                            enemy_shoot <= slot_oh_s;
                            enemy_col   <= sel_col_s;
                        end else begin
                            state_r     <= ST_SELECT;
                            enemy_shoot <= '0;
                            enemy_col   <= '0;
                        end
                    end
                    ST_FIRE: begin
                        state_r     <= ST_COOLDOWN;
                        cd_cnt_r    <= CD_RELOAD;
                        enemy_shoot <= '0;
                        enemy_col   <= '0;
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        cd_cnt_r    <= 8'd0;
                        enemy_shoot <= '0;
                        enemy_col   <= '0;
                    end
                endcase
            end
        end
    end

    assign sched_state = state_r;

endmodule

// File: tb/tb_missile_scheduler.sv
// Directed bench for missile_scheduler with a timestamp-based reference model checked every cycle.
module tb_missile_scheduler;

    localparam int NS = 4;
    localparam int NC = 8;
    localparam int EC = 3;
    localparam int CWB = $clog2(NC);

    logic          frame_clk = 1'b0;
    logic          Reset;
    logic          game_active;
    logic          player_fire;
    logic          player_busy;
    logic [NS-1:0] enemy_busy;
    logic [NC-1:0] col_alive;
    logic          player_shoot;
    logic [NS-1:0] enemy_shoot;
    logic [CWB-1:0] enemy_col;
    logic [1:0]    sched_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 frame_clk = ~frame_clk;

    missile_scheduler #(
        .NUM_SLOTS      (NS),
        .NUM_COLS       (NC),
        .ENEMY_COOLDOWN (EC)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .game_active  (game_active),
        .player_fire  (player_fire),
        .player_busy  (player_busy),
        .enemy_busy   (enemy_busy),
        .col_alive    (col_alive),
        .player_shoot (player_shoot),
        .enemy_shoot  (enemy_shoot),
        .enemy_col    (enemy_col),
        .sched_state  (sched_state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: enemy launches are scheduled by the edge number at which
    // a launch becomes permitted, rather than by tracking FSM states.
    int          cyc = 0;
    logic        model_ok = 1'b0;
    logic        m_active;
    int          ready_at;
    int          m_ptr;
    logic        m_prev;
    logic        m_pend;
    logic        m_edge;
    logic        x_pshoot;
    logic [NS-1:0] x_eshoot;
    int          x_ecol;
    int          x_state;
    int          m_col;
    int          m_slot;

    always @(posedge frame_clk) begin
        cyc = cyc + 1;
        if (Reset) begin
            model_ok = 1'b1;
            m_active = 1'b0;
            m_ptr    = 0;
            m_prev   = 1'b0;
            m_pend   = 1'b0;
            x_pshoot = 1'b0;
            x_eshoot = '0;
            x_ecol   = 0;
            x_state  = 0;
        end else begin
            m_edge = player_fire && !m_prev;
            m_prev = player_fire;
`ifdef MISSILE_SCHED_FIRE_BUFFER_EN
            if (m_edge || m_pend) begin
                if (!(player_busy || x_pshoot)) begin
                    x_pshoot = 1'b1;
                    m_pend   = 1'b0;
                end else begin
                    x_pshoot = 1'b0;
                    m_pend   = 1'b1;
                end
            end else begin
                x_pshoot = 1'b0;
            end
`else
            x_pshoot = m_edge && !player_busy;
`endif
            x_eshoot = '0;
            x_ecol   = 0;
            m_col    = -1;
            m_slot   = -1;
            for (int k = 0; k < NC; k++) begin
                if (m_col < 0 && ((int'(col_alive) >> ((m_ptr + k) % NC)) & 1) == 1)
                    m_col = (m_ptr + k) % NC;
            end
            for (int s = 0; s < NS; s++) begin
                if (m_slot < 0 && ((int'(enemy_busy) >> s) & 1) == 0)
                    m_slot = s;
            end
            if (!game_active) begin
                m_active = 1'b0;
                x_state  = 0;
            end else if (!m_active) begin
                m_active = 1'b1;
                ready_at = cyc + EC + 1;
                x_state  = 1;
            end else if (cyc >= ready_at && m_col >= 0 && m_slot >= 0) begin
                x_eshoot = NS'(1 << m_slot);
                x_ecol   = m_col;
                m_ptr    = (m_col + 1) % NC;
                ready_at = cyc + EC + 2;
                x_state  = 3;
            end else begin
                x_state  = (cyc >= ready_at - 1) ? 2 : 1;
            end
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    always @(negedge frame_clk) begin
        if (model_ok) begin
            check("player_shoot", int'(player_shoot), int'(x_pshoot));
            check("enemy_shoot",  int'(enemy_shoot),  int'(x_eshoot));
            check("enemy_col",    int'(enemy_col),    x_ecol);
            check("sched_state",  int'(sched_state),  x_state);
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge frame_clk);
        #1;
    endtask

    task automatic wait_launch(input string name, input int limit, output int took);
        step(1);
        took = 1;
        while (enemy_shoot == '0 && took < limit) begin
            step(1);
            took++;
        end
        if (enemy_shoot == '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no enemy_shoot within %0d cycles", name, limit);
        end
    endtask

    task automatic wait_state(input string name, input int st, input int limit);
        int took;
        step(1);
        took = 1;
        while (int'(sched_state) != st && took < limit) begin
            step(1);
            took++;
        end
        if (int'(sched_state) != st) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: sched_state %0d, expected %0d within %0d cycles",
                     name, sched_state, st, limit);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int took;
        int pulses;
        int first_at;
        int held;

        Reset = 1'b1; game_active = 1'b0; player_fire = 1'b0; player_busy = 1'b0;
        enemy_busy = '0; col_alive = '0;
        step(2);
        check("rst_player_shoot", int'(player_shoot), 0);
        check("rst_enemy_shoot",  int'(enemy_shoot),  0);
        check("rst_enemy_col",    int'(enemy_col),    0);
        check("rst_sched_state",  int'(sched_state),  0);
        Reset = 1'b0;
        step(1);

        // Fire held for 10 cycles: one pulse, visible right after the edge.
        player_fire = 1'b1;
        pulses = 0; first_at = -1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (player_shoot) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check("hold_fire_pulses", pulses, 1);
        check("hold_fire_latency", first_at, 0);
        player_fire = 1'b0;
        step(2);

        // Regular enemy launches on successive columns every EC+2 cycles.
        col_alive = 8'hFF; game_active = 1'b1;
        wait_launch("launch_a0", 20, took);
        check("first_launch_delay", took, 5);
        check("launch_a0_slot", int'(enemy_shoot), 1);
        check("launch_a0_col", int'(enemy_col), 0);
        wait_launch("launch_a1", 20, took);
        check("launch_a1_period", took, 5);
        check("launch_a1_col", int'(enemy_col), 1);
        wait_launch("launch_a2", 20, took);
        check("launch_a2_period", took, 5);
        check("launch_a2_col", int'(enemy_col), 2);

        // Reset during FIRE cancels the launch and clears the column pointer.
        Reset = 1'b1;
        step(1);
        check("rst_fire_enemy_shoot", int'(enemy_shoot), 0);
        check("rst_fire_state", int'(sched_state), 0);
        Reset = 1'b0;
        wait_launch("launch_b0", 20, took);
        check("launch_b0_delay", took, 5);
        check("launch_b0_col", int'(enemy_col), 0);
        wait_launch("launch_b1", 20, took);
        check("launch_b1_col", int'(enemy_col), 1);

        // Sparse columns from col_ptr=2: 7 then wrap to 1.
        col_alive = 8'b1000_0010;
        wait_launch("launch_w0", 20, took);
        check("wrap_col_first", int'(enemy_col), 7);
        wait_launch("launch_w1", 20, took);
        check("wrap_col_second", int'(enemy_col), 1);

        // All slots busy holds SELECT; freeing slot 2 launches it.
        enemy_busy = 4'b1111;
        wait_state("reach_select_busy", 2, 20);
        held = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sched_state == 2'd2 && enemy_shoot == '0) held++;
        end
        check("busy_hold_cycles", held, 20);
        enemy_busy = 4'b1011;
        step(1);
        check("free_slot2_shoot", int'(enemy_shoot), 4);
        check("free_slot2_col", int'(enemy_col), 7);
        check("free_slot2_state", int'(sched_state), 3);

        // game_active dropped in SELECT: IDLE next cycle and no pulse even though a launch was possible.
        enemy_busy = 4'b1111;
        wait_state("reach_select_drop", 2, 20);
        enemy_busy = '0; game_active = 1'b0;
        step(1);
        check("drop_state", int'(sched_state), 0);
        check("drop_no_shoot", int'(enemy_shoot), 0);
        step(3);

        // No live columns holds SELECT; one column appearing launches from it.
        col_alive = '0; game_active = 1'b1;
        wait_state("reach_select_empty", 2, 20);
        step(5);
        check("empty_hold_state", int'(sched_state), 2);
        col_alive = 8'h10;
        step(1);
        check("late_col_shoot", int'(enemy_shoot), 1);
        check("late_col_col", int'(enemy_col), 4);
        game_active = 1'b0;
        step(2);

        // Fire edge while the player missile is busy; busy clears 6 cycles after the edge.
        pulses = 0; first_at = -1;
        player_busy = 1'b1; player_fire = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (player_shoot) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
            if (i == 1) player_fire = 1'b0;
            if (i == 5) player_busy = 1'b0;
        end
`ifdef MISSILE_SCHED_FIRE_BUFFER_EN
        check("busy_fire_pulses", pulses, 1);
        check("busy_fire_latency", first_at, 6);
`else
        check("busy_fire_pulses", pulses, 0);
`endif

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
